// File: rtl/write_through_buffer.sv
// Posted-write FIFO between the write-through cache path and main memory, with block-level RAW hazard detection.
// Optional macro WTB_COALESCE_EN: a store that hits the youngest entry's address (not in flight) overwrites it in place.
module write_through_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int OFF_W  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_valid,
    input  logic [ADDR_W-1:0]      wr_addr,
    input  logic [DATA_W-1:0]      wr_data,
    output logic                   wr_ready,
    input  logic                   rd_req,
    input  logic [ADDR_W-1:0]      rd_addr,
    output logic                   rd_conflict,
    output logic                   mem_write,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [DATA_W-1:0]      mem_data,
    input  logic                   mem_ready,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_data_q, mem_data_d;

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [ADDR_W-1:0] addr_d [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];

    logic              full;
    logic              push;
    logic              pop;
    logic              coal_hit;
    logic [PTR_W-1:0]  load_idx;
    logic [ADDR_W-1:0] load_addr;
    logic [DATA_W-1:0] load_data;
    logic [DEPTH-1:0]  hit_vec;
    logic              rd_off_unused;

    assign full = !(count_q < FULL_CNT);

`ifdef WTB_COALESCE_EN
    logic [PTR_W-1:0] young_idx;
    logic             coal_match;

    // The in-flight head must stay stable on the memory bus, so it is never a coalesce target.
    assign young_idx  = tail_q - PTR_W'(1);
    assign coal_match = (count_q != '0) && (addr_q[young_idx] == wr_addr)
                        && !((state_q == BUSY) && (count_q == CNT_W'(1)));
    assign coal_hit   = wr_valid && coal_match;
    assign wr_ready   = !full || coal_match;
`else
    assign coal_hit   = 1'b0;
    assign wr_ready   = !full;
`endif

    assign push = wr_valid && wr_ready && !coal_hit;
    assign pop  = (state_q == BUSY) && mem_ready;

    always_comb begin
        head_d  = pop  ? head_q + PTR_W'(1) : head_q;
        tail_d  = push ? tail_q + PTR_W'(1) : tail_q;
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            addr_d[i] = addr_q[i];
            data_d[i] = data_q[i];
        end
        if (push) begin
            addr_d[tail_q] = wr_addr;
            data_d[tail_q] = wr_data;
        end
`ifdef WTB_COALESCE_EN
        if (coal_hit) begin
            data_d[young_idx] = wr_data;
        end
`endif
    end

    // Loading from the next-state storage lets a same-cycle push or coalesce reach the memory bus directly.
    always_comb begin
        load_idx  = (state_q == BUSY) ? head_q + PTR_W'(1) : head_q;
        load_addr = addr_d[load_idx];
        load_data = data_d[load_idx];
    end

    always_comb begin
        state_d     = state_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_data_d  = mem_data_q;
        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    state_d     = BUSY;
                    mem_write_d = 1'b1;
                    mem_addr_d  = load_addr;
                    mem_data_d  = load_data;
                end
            end
            BUSY: begin
                if (mem_ready) begin
                    if (count_d != '0) begin
                        mem_addr_d = load_addr;
                        mem_data_d = load_data;
                    end else begin
                        state_d     = IDLE;
                        mem_write_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d     = IDLE;
                mem_write_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
        end
    end

    // Entry contents need no reset: occupancy alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
        logic [PTR_W-1:0] rel_idx;
        assign rel_idx     = PTR_W'(gi) - head_q;
        assign hit_vec[gi] = ({1'b0, rel_idx} < count_q)
                             && (addr_q[gi][ADDR_W-1:OFF_W] == rd_addr[ADDR_W-1:OFF_W]);
    end

    assign rd_off_unused = ^rd_addr[OFF_W-1:0];
    assign rd_conflict   = rd_req && (|hit_vec);

    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_data  = mem_data_q;
    assign count     = count_q;
    assign empty     = (count_q == '0) && (state_q == IDLE);

endmodule

// File: tb/tb_write_through_buffer.sv
// Scoreboard bench for write_through_buffer: expected stores queued on acceptance, compared as memory takes them.
`timescale 1ns/1ps
module tb_write_through_buffer;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 3;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_conflict;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              mem_ready;
    logic              empty;
    logic [CNT_W-1:0]  count;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_pass   = 0;
    int  n_mem    = 0;
    bit  mem_hold = 1'b1;
    int  mem_lat  = 1;

    write_through_buffer dut (
        .clk         (clk),
        .rst         (rst),
        .wr_valid    (wr_valid),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_ready    (wr_ready),
        .rd_req      (rd_req),
        .rd_addr     (rd_addr),
        .rd_conflict (rd_conflict),
        .mem_write   (mem_write),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .mem_ready   (mem_ready),
        .empty       (empty),
        .count       (count)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Memory model: pulses mem_ready mem_lat cycles into each request unless held off.
    initial begin : mem_model
        int  wait_cnt;
        wr_t e;
        wait_cnt  = 0;
        mem_ready = 1'b0;
        forever begin
            @(negedge clk);
            mem_ready = 1'b0;
            if (rst || mem_hold || !mem_write) begin
                wait_cnt = 0;
            end else if (wait_cnt < mem_lat) begin
                wait_cnt++;
            end else begin
                wait_cnt  = 0;
                mem_ready = 1'b1;
                check_val("sb_pending", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check_val("mem_addr", 64'(mem_addr), 64'(e.addr));
                    check_val("mem_data", 64'(mem_data), 64'(e.data));
                end
                $display("mem write %0d: addr=0x%03h data=0x%08h", n_mem, mem_addr, mem_data);
                n_mem++;
            end
        end
    end

    // Called at a falling edge; returns at the falling edge after the accepting clock edge.
    task automatic store(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input bit push_exp);
        int  waited;
        wr_t e;
        waited   = 0;
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        #1;
        while (!wr_ready && waited < 200) begin
            @(negedge clk);
            #1;
            waited++;
        end
        check_val("store_accept", 64'(wr_ready), 64'd1);
        if (!wr_ready) begin
            wr_valid = 1'b0;
            @(negedge clk);
            return;
        end
        if (push_exp) begin
            e.addr = a;
            e.data = d;
            exp_q.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (!(empty && exp_q.size() == 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check_val({tag, "_empty"}, 64'(empty), 64'd1);
        check_val({tag, "_count"}, 64'(count), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DATA_W-1:0] dv;
        wr_t               e;
        int                base;

        rst      = 1'b1;
        wr_valid = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        rd_req   = 1'b0;
        rd_addr  = '0;
        repeat (2) @(negedge clk);
        check_val("rst_count", 64'(count), 64'd0);
        check_val("rst_empty", 64'(empty), 64'd1);
        check_val("rst_wr_ready", 64'(wr_ready), 64'd1);
        check_val("rst_mem_write", 64'(mem_write), 64'd0);
        check_val("rst_mem_addr", 64'(mem_addr), 64'd0);
        check_val("rst_mem_data", 64'(mem_data), 64'd0);
        check_val("rst_rd_conflict", 64'(rd_conflict), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single store with 3-cycle memory latency
        mem_hold = 1'b0;
        mem_lat  = 3;
        store(10'h004, 32'hDEADBEEF, 1'b1);
        wr_valid = 1'b0;
        check_val("t1_mem_write_k", 64'(mem_write), 64'd0);
        check_val("t1_count_k", 64'(count), 64'd1);
        check_val("t1_empty_k", 64'(empty), 64'd0);
        @(negedge clk);
        check_val("t1_mem_write_k1", 64'(mem_write), 64'd1);
        check_val("t1_mem_addr_k1", 64'(mem_addr), 64'h004);
        check_val("t1_mem_data_k1", 64'(mem_data), 64'hDEADBEEF);
        wait_drain("t1");
        check_val("t1_mem_write_end", 64'(mem_write), 64'd0);

        // Fill to DEPTH with memory stalled; fifth store waits for the first pop
        mem_hold = 1'b1;
        mem_lat  = 1;
        base     = n_mem;
        for (int i = 0; i < 4; i++) store(10'h100 + 10'(i), 32'hA000_0000 + 32'(i), 1'b1);
        check_val("t2_full_ready", 64'(wr_ready), 64'd0);
        check_val("t2_full_count", 64'(count), 64'd4);
        wr_valid = 1'b1;
        wr_addr  = 10'h104;
        wr_data  = 32'hA000_0004;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check_val("t2_hold_ready", 64'(wr_ready), 64'd0);
            check_val("t2_hold_count", 64'(count), 64'd4);
        end
        mem_hold = 1'b0;
        store(10'h104, 32'hA000_0004, 1'b1);
        wr_valid = 1'b0;
        check_val("t2_after_ready", 64'((n_mem - base) >= 1), 64'd1);
        wait_drain("t2");

        // Pointer wrap: ten stores, memory ready every second cycle
        mem_lat = 1;
        for (int i = 0; i < 10; i++) begin
            dv = $urandom;
            store(10'h200 + 10'(i * 7), dv, 1'b1);
        end
        wr_valid = 1'b0;
        wait_drain("t3");

        // Hazard detection on a pending store
        mem_hold = 1'b1;
        store(10'h011, 32'h1111_1111, 1'b1);
        wr_valid = 1'b0;
        rd_req   = 1'b1;
        rd_addr  = 10'h013;
        #1 check_val("t4_same_block", 64'(rd_conflict), 64'd1);
        rd_addr = 10'h014;
        #1 check_val("t4_next_block", 64'(rd_conflict), 64'd0);
        rd_addr = 10'h010;
        #1 check_val("t4_block_base", 64'(rd_conflict), 64'd1);
        rd_req  = 1'b0;
        rd_addr = 10'h013;
        #1 check_val("t4_no_req", 64'(rd_conflict), 64'd0);
        rd_req   = 1'b1;
        mem_hold = 1'b0;
        wait_drain("t4");
        check_val("t4_after_drain", 64'(rd_conflict), 64'd0);

        // Store in the same cycle as the read check must not flag until the next cycle
        mem_hold = 1'b1;
        rd_addr  = 10'h041;
        wr_valid = 1'b1;
        wr_addr  = 10'h040;
        wr_data  = 32'h4040_4040;
        #1;
        check_val("t4_same_cycle", 64'(rd_conflict), 64'd0);
        check_val("t4_wr_ready", 64'(wr_ready), 64'd1);
        e.addr = 10'h040;
        e.data = 32'h4040_4040;
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        wr_valid = 1'b0;
        check_val("t4_next_cycle", 64'(rd_conflict), 64'd1);
        rd_req = 1'b0;

        // Reset while draining with three entries held
        store(10'h050, 32'h5050_5050, 1'b1);
        store(10'h060, 32'h6060_6060, 1'b1);
        wr_valid = 1'b0;
        check_val("t5_count", 64'(count), 64'd3);
        check_val("t5_busy", 64'(mem_write), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        exp_q.delete();
        check_val("t5_mem_write", 64'(mem_write), 64'd0);
        check_val("t5_count_rst", 64'(count), 64'd0);
        check_val("t5_wr_ready", 64'(wr_ready), 64'd1);
        check_val("t5_empty", 64'(empty), 64'd1);
        rst = 1'b0;
        @(negedge clk);
        mem_hold = 1'b0;
        store(10'h070, 32'h7070_7070, 1'b1);
        wr_valid = 1'b0;
        wait_drain("t5_post");

`ifdef WTB_COALESCE_EN
        // Coalesce into the youngest entry while the head is in flight
        mem_hold = 1'b1;
        store(10'h020, 32'hAAAA_AAAA, 1'b1);
        wr_valid = 1'b0;
        @(negedge clk);
        check_val("t6_in_flight", 64'(mem_write), 64'd1);
        store(10'h030, 32'hBBBB_BBBB, 1'b1);
        store(10'h030, 32'hCCCC_CCCC, 1'b0);
        wr_valid = 1'b0;
        e = exp_q.pop_back();
        e.data = 32'hCCCC_CCCC;
        exp_q.push_back(e);
        check_val("t6_count", 64'(count), 64'd2);
        mem_hold = 1'b0;
        wait_drain("t6");
`endif

        check_val("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
